// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Brief    : Field layout, opcode names and slicing helper for the decoder
// Revision : 1.0
// ============================================================================
package decoder_pkg;

    localparam int OPCODE_W   = 4;
    localparam int OPCODE_LSB = 0;
    localparam int REG_W      = 14;
    localparam int REG_LSB    = 4;
    localparam int DATA_W     = 32;
    localparam int CTRL_W     = 32;

    // Opcode names consumed by the downstream executor
    localparam logic [OPCODE_W-1:0] OP_NOP      = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_MOVE     = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ROTATE   = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_GRIP     = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_RELEASE  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_WRITE    = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_READ     = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_HOME     = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_STOP     = 4'hF;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    register;
        logic [DATA_W-1:0]   data;
    } instr_fields_t;

    // Pure bit slicing; the reserved upper control bits are discarded
    function automatic instr_fields_t split_instr(
        input logic [CTRL_W-1:0] ctrl,
        input logic [DATA_W-1:0] payload
    );
        instr_fields_t f;
        f.opcode   = ctrl[OPCODE_LSB +: OPCODE_W];
        f.register = ctrl[REG_LSB +: REG_W];
        f.data     = payload;
        return f;
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decorder_instruction.sv
`default_nettype none
// ============================================================================
// Module   : decorder_instruction
// Brief    : Captures a 64-bit instruction on a falling request edge and holds
//            its opcode, register field and payload for the executor
// Revision : 1.0
// ============================================================================
module decorder_instruction
    import decoder_pkg::*;
(
    input  logic                clk_en,
    input  logic                rst_n,
    input  logic                new_instruction,
    input  logic [CTRL_W-1:0]   dataA,
    input  logic [DATA_W-1:0]   dataB,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [REG_W-1:0]    out_register,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid
);

    logic          ni_prev_q, ni_prev_d;
    instr_fields_t fields_q,  fields_d;
    logic          valid_q,   valid_d;
    logic          accept;
    instr_fields_t decoded;

    assign decoded = split_instr(dataA, dataB);

    // Request is active-low: accept only on a sampled high-to-low transition
    assign accept = ~new_instruction & ni_prev_q;

    always_comb begin
        ni_prev_d = new_instruction;
        fields_d  = fields_q;
        valid_d   = 1'b0;
        if (accept) begin
            fields_d = decoded;
            valid_d  = 1'b1;
        end
    end

    // ni_prev resets high so a request held low across reset is still taken
    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            ni_prev_q <= 1'b1;
            fields_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            ni_prev_q <= ni_prev_d;
            fields_q  <= fields_d;
            valid_q   <= valid_d;
        end
    end

    assign out_opcode   = fields_q.opcode;
    assign out_register = fields_q.register;
    assign out_data     = fields_q.data;
    assign out_valid    = valid_q;

endmodule : decorder_instruction
`default_nettype wire

// File: tb/tb_decorder_instruction.sv
`default_nettype none
// ============================================================================
// Module   : tb_decorder_instruction
// Brief    : Table vectors, reset corner cases and random traffic vs a model
// Revision : 1.0
// ============================================================================
module tb_decorder_instruction;

    logic        clk_en;
    logic        rst_n;
    logic        new_instruction;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [3:0]  out_opcode;
    logic [13:0] out_register;
    logic [31:0] out_data;
    logic        out_valid;

    int n_pass  = 0;
    int n_total = 0;

    decorder_instruction dut (
        .clk_en          (clk_en),
        .rst_n           (rst_n),
        .new_instruction (new_instruction),
        .dataA           (dataA),
        .dataB           (dataB),
        .out_opcode      (out_opcode),
        .out_register    (out_register),
        .out_data        (out_data),
        .out_valid       (out_valid)
    );

    initial clk_en = 1'b0;
    always #5 clk_en = ~clk_en;

    // Reference model: remembers the last sampled request level and the
    // fields of the most recently accepted instruction
    bit          m_prev;
    int unsigned m_op, m_reg, m_data;
    bit          m_valid;

    function automatic void model_reset();
        m_prev = 1'b1; m_op = 0; m_reg = 0; m_data = 0; m_valid = 1'b0;
    endfunction

    function automatic void model_step(bit ni, int unsigned a, int unsigned b);
        if (ni == 1'b0 && m_prev == 1'b1) begin
            m_op    = a % 16;
            m_reg   = (a / 16) % 16384;
            m_data  = b;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        m_prev = ni;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [3:0] op,
                           input logic [13:0] rg, input logic [31:0] d);
        chk({tag, ".valid"},    {31'd0, out_valid},    {31'd0, v});
        chk({tag, ".opcode"},   {28'd0, out_opcode},   {28'd0, op});
        chk({tag, ".register"}, {18'd0, out_register}, {18'd0, rg});
        chk({tag, ".data"},     out_data,              d);
    endtask

    task automatic apply_cycle(input logic ni, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_en);
        new_instruction = ni;
        dataA = a;
        dataB = b;
        @(posedge clk_en);
        #1;
        model_step(ni, a, b);
    endtask

    typedef struct {
        logic        ni;
        logic [31:0] a;
        logic [31:0] b;
        logic        v;
        logic [3:0]  op;
        logic [13:0] rg;
        logic [31:0] d;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic ni, logic [31:0] a, logic [31:0] b,
                                logic v, logic [3:0] op, logic [13:0] rg, logic [31:0] d);
        vec_t r;
        r.ni = ni; r.a = a; r.b = b; r.v = v; r.op = op; r.rg = rg; r.d = d;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'h0, 14'h0000, 32'h0000_0000);
        vecs[1]  = mk(1'b0, 32'h0003_FFF1, 32'h0000_0038, 1'b1, 4'h1, 14'h3FFF, 32'h0000_0038);
        vecs[2]  = mk(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 4'h1, 14'h3FFF, 32'h0000_0038);
        vecs[3]  = mk(1'b0, 32'h0000_0000, 32'h2642_5800, 1'b1, 4'h0, 14'h0000, 32'h2642_5800);
        vecs[4]  = mk(1'b0, 32'h0000_0000, 32'h0000_000A, 1'b0, 4'h0, 14'h0000, 32'h2642_5800);
        vecs[5]  = mk(1'b0, 32'h0000_0005, 32'h0000_000B, 1'b0, 4'h0, 14'h0000, 32'h2642_5800);
        vecs[6]  = mk(1'b0, 32'h0000_0000, 32'h0000_000C, 1'b0, 4'h0, 14'h0000, 32'h2642_5800);
        vecs[7]  = mk(1'b0, 32'h0000_0000, 32'h0000_000D, 1'b0, 4'h0, 14'h0000, 32'h2642_5800);
        vecs[8]  = mk(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'h0, 14'h0000, 32'h2642_5800);
        vecs[9]  = mk(1'b0, 32'hFFFC_0005, 32'h0000_1234, 1'b1, 4'h5, 14'h0000, 32'h0000_1234);
        vecs[10] = mk(1'b1, 32'h0003_FFF2, 32'h0000_0055, 1'b0, 4'h5, 14'h0000, 32'h0000_1234);
        vecs[11] = mk(1'b0, 32'h0003_FFF2, 32'h0000_0055, 1'b1, 4'h2, 14'h3FFF, 32'h0000_0055);
        vecs[12] = mk(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'h2, 14'h3FFF, 32'h0000_0055);
        vecs[13] = mk(1'b0, 32'h0000_0019, 32'hFFFF_FFFF, 1'b1, 4'h9, 14'h0001, 32'hFFFF_FFFF);
        vecs[14] = mk(1'b1, 32'hABCD_0123, 32'h0000_0000, 1'b0, 4'h9, 14'h0001, 32'hFFFF_FFFF);
        vecs[15] = mk(1'b0, 32'h0004_0000, 32'h0000_0000, 1'b1, 4'h0, 14'h0000, 32'h0000_0000);

        rst_n = 1'b1;
        new_instruction = 1'b0;
        dataA = 32'h1234_5678;
        dataB = 32'h9ABC_DEF0;
        model_reset();

        // Asynchronous reset, checked before the first clock edge
        #1 rst_n = 1'b0;
        #1 chk_all("reset_async", 1'b0, 4'h0, 14'h0000, 32'h0);
        @(posedge clk_en);
        @(negedge clk_en);
        new_instruction = 1'b1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_cycle(vecs[i].ni, vecs[i].a, vecs[i].b);
            chk_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].op, vecs[i].rg, vecs[i].d);
        end

        // Reset mid-operation with the request held low across release
        @(negedge clk_en);
        new_instruction = 1'b0;
        dataA = 32'h0001_2347;
        dataB = 32'hCAFE_F00D;
        #2 rst_n = 1'b0;
        #1 chk_all("midreset_clear", 1'b0, 4'h0, 14'h0000, 32'h0);
        model_reset();
        @(posedge clk_en);
        #1 chk_all("midreset_held", 1'b0, 4'h0, 14'h0000, 32'h0);
        @(negedge clk_en);
        rst_n = 1'b1;
        @(posedge clk_en);
        #1;
        model_step(1'b0, 32'h0001_2347, 32'hCAFE_F00D);
        chk_all("release_low", 1'b1, 4'h7, 14'h1234, 32'hCAFE_F00D);
        apply_cycle(1'b0, 32'h0000_0003, 32'h0000_0001);
        chk_all("release_hold", 1'b0, 4'h7, 14'h1234, 32'hCAFE_F00D);

        // Random traffic; request biased low so holds and back-to-back both occur
        for (int i = 0; i < 300; i++) begin
            logic ni;
            ni = ($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1;
            apply_cycle(ni, $urandom, $urandom);
            chk_all($sformatf("rand%0d", i), m_valid, m_op[3:0], m_reg[13:0], m_data);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_decorder_instruction
`default_nettype wire
